// File: rtl/result_serializer.sv
// Two-slot column buffer that serializes LayerNorm result columns onto a valid/ready word stream.
// Build option: define RESULT_SER_DROP_CNT_EN to add a saturating 8-bit drop_count output.
module result_serializer #(
    parameter int D_MODEL    = 64,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          result_valid,
    input  logic [D_MODEL*DATA_WIDTH-1:0] result_in,
    output logic                          out_word_valid,
    output logic [DATA_WIDTH-1:0]         out_word,
    input  logic                          out_word_ready,
    output logic                          out_last,
    output logic [1:0]                    cols_pending,
    output logic                          overflow
`ifdef RESULT_SER_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_count
`endif
);

    localparam int IDX_W = $clog2(D_MODEL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D_MODEL - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                                state;
    logic                                  wr_ptr;
    logic                                  rd_ptr;
    logic [IDX_W-1:0]                      word_idx;
    logic [D_MODEL-1:0][DATA_WIDTH-1:0]    slot [2];

    logic       xfer;
    logic       last_xfer;
    logic       capture;
    logic       drop;
    logic [1:0] pending_next;

    // A full buffer can still accept a column on the edge its final word leaves.
    always_comb begin
        xfer         = 1'b0;
        last_xfer    = 1'b0;
        capture      = 1'b0;
        drop         = 1'b0;
        pending_next = cols_pending;
        xfer         = out_word_valid && out_word_ready;
        last_xfer    = xfer && (word_idx == LAST_IDX);
        capture      = result_valid && ((cols_pending != 2'd2) || last_xfer);
        drop         = result_valid && !capture;
        pending_next = cols_pending + {1'b0, capture} - {1'b0, last_xfer};
    end

    assign out_word_valid = (state == STREAM);
    assign out_word       = out_word_valid ? slot[rd_ptr][word_idx] : '0;
    assign out_last       = out_word_valid && (word_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            word_idx     <= '0;
            cols_pending <= 2'd0;
            overflow     <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                if (word_idx == LAST_IDX) begin
                    word_idx <= '0;
                    rd_ptr   <= ~rd_ptr;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
            cols_pending <= pending_next;
            state        <= (pending_next != 2'd0) ? STREAM : IDLE;
            overflow     <= drop;
        end
    end

    // Slot storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot[wr_ptr] <= result_in;
        end
    end

`ifdef RESULT_SER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: scoreboard of expected words plus a table of control steps.
// Checks drop_count as well when RESULT_SER_DROP_CNT_EN is defined.
module tb_result_serializer;

    localparam int D_MODEL = 64;
    localparam int DW      = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   result_valid;
    logic [D_MODEL*DW-1:0]  result_in;
    logic                   out_word_valid;
    logic [DW-1:0]          out_word;
    logic                   out_word_ready;
    logic                   out_last;
    logic [1:0]             cols_pending;
    logic                   overflow;
`ifdef RESULT_SER_DROP_CNT_EN
    logic [7:0]             drop_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] word;
        logic          last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          rv;
        logic [DW-1:0] base;
        logic          rdy;
        logic          accept;
        logic          exp_valid;
        logic [1:0]    exp_pending;
        logic          exp_ovf;
    } vec_t;
    vec_t vecs[$];

    result_serializer #(.D_MODEL(D_MODEL), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .result_valid   (result_valid),
        .result_in      (result_in),
        .out_word_valid (out_word_valid),
        .out_word       (out_word),
        .out_word_ready (out_word_ready),
        .out_last       (out_last),
        .cols_pending   (cols_pending),
        .overflow       (overflow)
`ifdef RESULT_SER_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D_MODEL*DW-1:0] buildCol(input logic [DW-1:0] base);
        logic [D_MODEL*DW-1:0] v;
        v = '0;
        for (int k = 0; k < D_MODEL; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    task automatic pushColumn(input logic [DW-1:0] base);
        for (int k = 0; k < D_MODEL; k++) sb.push_back('{word: base + DW'(k), last: (k == D_MODEL-1)});
    endtask

    task automatic addVec(input logic rv, input logic [DW-1:0] base, input logic rdy, input logic accept,
                          input logic ev, input logic [1:0] ep, input logic eo);
        vecs.push_back('{rv: rv, base: base, rdy: rdy, accept: accept, exp_valid: ev, exp_pending: ep, exp_ovf: eo});
    endtask

    task automatic applyStimulus(input vec_t v);
        result_in      = buildCol(v.base);
        result_valid   = v.rv;
        out_word_ready = v.rdy;
        if (v.accept) pushColumn(v.base);
        tick();
        result_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int maxc);
        int n = 0;
        while ((sb.size() != 0 || out_word_valid) && n < maxc) begin
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, 32'((sb.size() == 0) && !out_word_valid), 32'd1);
        checkOutput({name, "_pending0"}, 32'(cols_pending), 32'd0);
    endtask

    // Every visible word must match the scoreboard head, stalled or not; it pops only on a transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_word_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word actual=%0h required=none at %0t", out_word, $time);
                end else begin
                    checkOutput("out_word", 32'(out_word), 32'(sb[0].word));
                    checkOutput("out_last", 32'(out_last), 32'(sb[0].last));
                    if (out_word_ready) void'(sb.pop_front());
                end
            end else begin
                checkOutput("idle_word", 32'(out_word), 32'd0);
                checkOutput("idle_last", 32'(out_last), 32'd0);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        result_valid   = 1'b0;
        result_in      = '0;
        out_word_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rst_valid", 32'(out_word_valid), 32'd0);
        checkOutput("rst_word", 32'(out_word), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_pending", 32'(cols_pending), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
`ifdef RESULT_SER_DROP_CNT_EN
        checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single column, word k = k+1, ready held high: 64 back-to-back words.
        out_word_ready = 1'b1;
        result_in      = buildCol(16'd1);
        result_valid   = 1'b1;
        pushColumn(16'd1);
        tick();
        result_valid = 1'b0;
        for (int i = 0; i < D_MODEL; i++) begin
            checkOutput("stream_valid", 32'(out_word_valid), 32'd1);
            tick();
        end
        checkOutput("single_end_valid", 32'(out_word_valid), 32'd0);
        checkOutput("single_end_pending", 32'(cols_pending), 32'd0);
        checkOutput("single_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: ready toggles every cycle.
        out_word_ready = 1'b0;
        result_in      = buildCol(16'h0100);
        result_valid   = 1'b1;
        pushColumn(16'h0100);
        tick();
        result_valid = 1'b0;
        for (int i = 0; i < 300 && (sb.size() != 0 || out_word_valid); i++) begin
            out_word_ready = ~out_word_ready;
            tick();
        end
        checkOutput("bp_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("bp_valid", 32'(out_word_valid), 32'd0);

        // Overflow: A and B buffered, C dropped, ready low throughout.
        addVec(1'b1, 16'h1000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        addVec(1'b1, 16'h2000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        addVec(1'b1, 16'h3000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_word_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_pending", i), 32'(cols_pending), 32'(vecs[i].exp_pending));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end
`ifdef RESULT_SER_DROP_CNT_EN
        checkOutput("ovf_drop_count", 32'(drop_count), 32'd1);
`endif
        out_word_ready = 1'b1;
        waitDrain("ovf", 200);

        // Capture lands on the same edge as A's final word while both slots are full.
        out_word_ready = 1'b0;
        result_valid   = 1'b1;
        result_in      = buildCol(16'h4000);
        pushColumn(16'h4000);
        tick();
        result_in = buildCol(16'h5000);
        pushColumn(16'h5000);
        tick();
        result_valid = 1'b0;
        checkOutput("bnd_full", 32'(cols_pending), 32'd2);
        out_word_ready = 1'b1;
        repeat (D_MODEL - 1) tick();
        result_in    = buildCol(16'h6000);
        result_valid = 1'b1;
        pushColumn(16'h6000);
        tick();
        result_valid = 1'b0;
        checkOutput("bnd_ovf", 32'(overflow), 32'd0);
        checkOutput("bnd_pending", 32'(cols_pending), 32'd2);
        waitDrain("bnd", 300);

        // Reset while word 20 of a column is on the output.
        result_in    = buildCol(16'h7000);
        result_valid = 1'b1;
        pushColumn(16'h7000);
        tick();
        result_valid = 1'b0;
        repeat (20) tick();
        checkOutput("pre_rst_word", 32'(out_word), 32'h7014);
        rst_n = 1'b0;
        sb.delete();
        tick();
        checkOutput("mid_rst_valid", 32'(out_word_valid), 32'd0);
        checkOutput("mid_rst_word", 32'(out_word), 32'd0);
        checkOutput("mid_rst_pending", 32'(cols_pending), 32'd0);
        rst_n        = 1'b1;
        result_in    = buildCol(16'h8000);
        result_valid = 1'b1;
        pushColumn(16'h8000);
        tick();
        result_valid = 1'b0;
        checkOutput("post_rst_first", 32'(out_word), 32'h8000);
        waitDrain("post_rst", 200);

        // Sustained drops: one overflow pulse per cycle, counter saturates.
        out_word_ready = 1'b0;
        result_valid   = 1'b1;
        result_in      = buildCol(16'h9000);
        pushColumn(16'h9000);
        tick();
        result_in = buildCol(16'hA000);
        pushColumn(16'hA000);
        tick();
        result_in = buildCol(16'hB000);
        for (int i = 0; i < 300; i++) begin
            tick();
            checkOutput("drop_ovf", 32'(overflow), 32'd1);
        end
        checkOutput("drop_pending", 32'(cols_pending), 32'd2);
        result_valid = 1'b0;
        tick();
        checkOutput("drop_ovf_end", 32'(overflow), 32'd0);
`ifdef RESULT_SER_DROP_CNT_EN
        checkOutput("drop_count_sat", 32'(drop_count), 32'd255);
`endif
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        checkOutput("final_pending", 32'(cols_pending), 32'd0);
`ifdef RESULT_SER_DROP_CNT_EN
        checkOutput("final_drop_count", 32'(drop_count), 32'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
Sits directly downstream of the LayerNorm streaming controller. Captures each processed column, delivered as a full D_MODEL-word vector with a one-cycle valid pulse, into a 2-slot column buffer. Serializes the buffered columns word-by-word onto a valid/ready word interface that feeds the SPI transmit path. The upstream stage has no backpressure, so a column arriving when both slots are occupied is dropped and flagged.

Parameters:
D_MODEL, 64, words per column (must be a power of 2, at least 2)
DATA_WIDTH, 16, bits per word

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
result_valid  input  1  one-cycle pulse: result_in holds a complete column
result_in  input  D_MODEL*DATA_WIDTH  column vector; word k = bits [k*DATA_WIDTH +: DATA_WIDTH]
out_word_valid  output  1  out_word holds a valid word
out_word  output  DATA_WIDTH  current word
out_word_ready  input  1  sink accepts out_word this cycle
out_last  output  1  high with out_word_valid when the current word is word D_MODEL-1 of its column
cols_pending  output  2  occupied slots (0..2)
overflow  output  1  one-cycle pulse: a column was dropped

Behaviour:
- Reset: synchronous on rst_n=0 at a rising clk edge.
  - Clears wr_ptr, rd_ptr, word_idx, cols_pending and overflow.
  - After reset: out_word_valid=0, out_word=0, out_last=0, cols_pending=0, overflow=0.
  - Slot contents are not reset.
  - A reset mid-column discards all buffered data. No partial column resumes.
- State machine:
  - IDLE (cols_pending=0): out_word_valid=0.
  - STREAM (cols_pending>0): out_word_valid=1, out_word = slot[rd_ptr] word word_idx.
  - STREAM returns to IDLE after the last word of the last pending column is transferred.
- Capture: on result_valid with cols_pending<2, write result_in into slot[wr_ptr]; wr_ptr toggles; cols_pending increments.
  - Capture latency: result_valid at edge N gives out_word_valid=1 in the cycle after edge N (from IDLE).
- Transfer: occurs when out_word_valid && out_word_ready.
  - Not at the last word: word_idx increments.
  - At word_idx=D_MODEL-1: word_idx wraps to 0, rd_ptr toggles, cols_pending decrements.
  - With ready held high, one word per cycle and no bubbles between columns.
- out_word and out_last are combinational from registered state only. There is no combinational path from out_word_ready to any output.
- out_word is forced to 0 when out_word_valid=0.
- Simultaneous capture and final-word transfer (same edge):
  - cols_pending stays unchanged. This holds even at cols_pending=2: the column is accepted and no overflow occurs.
  - The write targets the slot being freed (wr_ptr==rd_ptr in this case).
- Overflow: result_valid with cols_pending=2 and no final-word transfer that cycle.
  - result_in is discarded; pointers and count are unchanged.
  - overflow=1 for exactly the next cycle. Back-to-back drops give back-to-back pulses.
- out_word holds stable while out_word_valid=1 and out_word_ready=0.

Optional Feature:
Macro RESULT_SER_DROP_CNT_EN.
- Defined: adds output port drop_count (8 bits).
  - Increments on each dropped column and saturates at 255.
  - Cleared only by reset.
- Undefined: no drop_count port and no counter logic. overflow behaviour is identical in both builds.

Test Plan:
- Single column:
  - Stimulus: word k = k+1; out_word_ready held 1; result_valid pulsed at edge N.
  - Required: out_word_valid rises after edge N; words 1..64 appear on 64 consecutive cycles; out_last only on word 64; then IDLE with cols_pending=0.
- Backpressure:
  - Stimulus: one column; out_word_ready toggled 1,0,1,0...
  - Required: out_word holds during ready=0; exactly 64 transfers in order; no duplicated or skipped word.
- Overflow:
  - Stimulus: out_word_ready=0; three result_valid pulses 5 cycles apart (columns A, B, C).
  - Required: cols_pending=2 after the second pulse; overflow pulses once after the third; after raising ready, the output is A then B (128 words); C never appears. With RESULT_SER_DROP_CNT_EN, drop_count=1.
- Simultaneous boundary:
  - Stimulus: cols_pending=2; result_valid asserted in the cycle column A's word 63 transfers.
  - Required: no overflow; cols_pending stays 2; the output sequence is A, B, C.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 edge while word_idx=20 of a column.
  - Required: the next cycle shows out_word_valid=0, out_word=0, cols_pending=0. A new column then starts output at word 0.
- Saturation (RESULT_SER_DROP_CNT_EN):
  - Stimulus: 300 drops with ready=0.
  - Required: drop_count=255.
